// File: rtl/register_file_mp_if.sv
// Decode-stage register file bus: writeback, issue scoreboard and packed read ports.
interface register_file_mp_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
);
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;

  modport master (
    output wr_en, wr_addr, wr_data, issue_en, issue_addr, rd_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, issue_en, issue_addr, rd_addr,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-read-port register file with per-register busy scoreboard,
// optional write-to-read forwarding and optional hardwired zero register.
module register_file_mp #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input logic               clk,
  input logic               rst,
  register_file_mp_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        regs [DEPTH];
  logic [DEPTH-1:0]         busy;
  logic [DEPTH-1:0]         busyNext;
  logic                     wrValid;
  logic                     issueValid;
  logic [ADDR_W-1:0]        rdAddrK;
  logic [NUM_RD*DATA_W-1:0] rdData;
  logic [NUM_RD-1:0]        rdBusy;

  // Register 0 swallows writes and issues when it is hardwired to zero.
  always_comb begin
    wrValid    = bus.wr_en;
    issueValid = bus.issue_en;
    if ((ZERO_REG != 0) && (bus.wr_addr == {ADDR_W{1'b0}})) begin
      wrValid = 1'b0;
    end else begin
      wrValid = bus.wr_en;
    end
    if ((ZERO_REG != 0) && (bus.issue_addr == {ADDR_W{1'b0}})) begin
      issueValid = 1'b0;
    end else begin
      issueValid = bus.issue_en;
    end
  end

  // Scoreboard next state: clear applied first so a same-address issue wins.
  always_comb begin
    busyNext = busy;
    if (wrValid) begin
      busyNext[bus.wr_addr] = 1'b0;
    end else begin
      busyNext = busy;
    end
    if (issueValid) begin
      busyNext[bus.issue_addr] = 1'b1;
    end else begin
      busyNext = busyNext;
    end
  end

  // Storage and scoreboard flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= {DATA_W{1'b0}};
      end
      busy <= {DEPTH{1'b0}};
    end else begin
      if (wrValid) begin
        regs[bus.wr_addr] <= bus.wr_data;
      end
      busy <= busyNext;
    end
  end

  // Zero-latency read ports; reset masks every port to zero.
  always_comb begin
    rdData  = {(NUM_RD*DATA_W){1'b0}};
    rdBusy  = {NUM_RD{1'b0}};
    rdAddrK = {ADDR_W{1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      rdAddrK = bus.rd_addr[k*ADDR_W +: ADDR_W];
      if (!rst) begin
        rdData[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rdBusy[k]                  = 1'b0;
      end else if ((ZERO_REG != 0) && (rdAddrK == {ADDR_W{1'b0}})) begin
        rdData[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rdBusy[k]                  = 1'b0;
      end else if ((BYPASS != 0) && wrValid && (bus.wr_addr == rdAddrK)) begin
        rdData[k*DATA_W +: DATA_W] = bus.wr_data;
        rdBusy[k]                  = 1'b0;
      end else begin
        rdData[k*DATA_W +: DATA_W] = regs[rdAddrK];
        rdBusy[k]                  = busy[rdAddrK];
      end
    end
  end

  assign bus.rd_data = rdData;
  assign bus.rd_busy = rdBusy;
endmodule

// File: tb/tb_register_file_mp.sv
// Directed checks on bypass / no-bypass instances, then a randomized run of a
// 3-port 32-bit zero-register instance against an array reference model.
module tb_register_file_mp;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  register_file_mp_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) ifA ();
  register_file_mp_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) ifB ();
  register_file_mp_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3)) ifC ();

  register_file_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(0), .BYPASS(1))
    dutA (.clk(clk), .rst(rst), .bus(ifA));
  register_file_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0))
    dutB (.clk(clk), .rst(rst), .bus(ifB));
  register_file_mp #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(1), .BYPASS(1))
    dutC (.clk(clk), .rst(rst), .bus(ifC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] refRegs [16];
  logic        refBusy [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Same stimulus to both 16-bit instances.
  task automatic drv(input logic we, input int wa, input logic [15:0] wd,
                     input logic ie, input int ia, input int r0, input int r1);
    ifA.wr_en = we;  ifA.wr_addr = 4'(wa);  ifA.wr_data = wd;
    ifA.issue_en = ie;  ifA.issue_addr = 4'(ia);
    ifA.rd_addr = {4'(r1), 4'(r0)};
    ifB.wr_en = we;  ifB.wr_addr = 4'(wa);  ifB.wr_data = wd;
    ifB.issue_en = ie;  ifB.issue_addr = 4'(ia);
    ifB.rd_addr = {4'(r1), 4'(r0)};
    #1;
  endtask

  task automatic chkAB(input string tag, input logic [15:0] aD, input logic aB,
                       input logic [15:0] bD, input logic bB);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_A_data%0d", tag, k), 64'(ifA.rd_data[k*16 +: 16]), 64'(aD));
      chk($sformatf("%s_A_busy%0d", tag, k), 64'(ifA.rd_busy[k]), 64'(aB));
      chk($sformatf("%s_B_data%0d", tag, k), 64'(ifB.rd_data[k*16 +: 16]), 64'(bD));
      chk($sformatf("%s_B_busy%0d", tag, k), 64'(ifB.rd_busy[k]), 64'(bB));
    end
  endtask

  initial begin
    logic        rnd_rst;
    logic        we, ie;
    logic [3:0]  wa, ia;
    logic [31:0] wd;
    logic [3:0]  ra [3];
    logic [31:0] expD;
    logic        expB;

    tests = 0;
    fails = 0;
    rst = 1'b0;
    drv(1'b0, 0, 16'h0000, 1'b0, 0, 0, 0);
    ifC.wr_en = 1'b0; ifC.wr_addr = 4'h0; ifC.wr_data = 32'h0;
    ifC.issue_en = 1'b0; ifC.issue_addr = 4'h0; ifC.rd_addr = 12'h000;
    tick();
    tick();
    rst = 1'b1;
    #1;

    // Reset state across every address
    for (int a = 0; a < 16; a++) begin
      drv(1'b0, 0, 16'h0000, 1'b0, 0, a, 15 - a);
      chkAB($sformatf("reset_a%0d", a), 16'h0000, 1'b0, 16'h0000, 1'b0);
    end

    // Write with same-cycle read
    drv(1'b1, 5, 16'hBEEF, 1'b0, 0, 5, 5);
    chkAB("wr_cycle", 16'hBEEF, 1'b0, 16'h0000, 1'b0);
    tick();
    drv(1'b0, 5, 16'h0000, 1'b0, 0, 5, 5);
    chkAB("wr_after", 16'hBEEF, 1'b0, 16'hBEEF, 1'b0);

    // Scoreboard set, then clear by writeback
    drv(1'b0, 0, 16'h0000, 1'b1, 3, 3, 3);
    tick();
    drv(1'b0, 0, 16'h0000, 1'b0, 0, 3, 3);
    chkAB("issue3", 16'h0000, 1'b1, 16'h0000, 1'b1);
    drv(1'b1, 3, 16'h1234, 1'b0, 0, 3, 3);
    chkAB("wb3_cycle", 16'h1234, 1'b0, 16'h0000, 1'b1);
    tick();
    drv(1'b0, 0, 16'h0000, 1'b0, 0, 3, 3);
    chkAB("wb3_after", 16'h1234, 1'b0, 16'h1234, 1'b0);

    // Simultaneous issue and write to the same register: set wins
    drv(1'b0, 0, 16'h0000, 1'b1, 7, 7, 7);
    tick();
    drv(1'b1, 7, 16'hABCD, 1'b1, 7, 7, 7);
    chkAB("same7_cycle", 16'hABCD, 1'b0, 16'h0000, 1'b1);
    tick();
    drv(1'b0, 0, 16'h0000, 1'b0, 0, 7, 7);
    chkAB("same7_after", 16'hABCD, 1'b1, 16'hABCD, 1'b1);

    // Set and clear on different addresses both take effect
    drv(1'b0, 0, 16'h0000, 1'b1, 9, 9, 10);
    tick();
    drv(1'b1, 9, 16'h5A5A, 1'b1, 10, 9, 10);
    tick();
    drv(1'b0, 0, 16'h0000, 1'b0, 0, 9, 10);
    chk("diff_A_busy9", 64'(ifA.rd_busy[0]), 64'd0);
    chk("diff_A_busy10", 64'(ifA.rd_busy[1]), 64'd1);
    chk("diff_B_busy9", 64'(ifB.rd_busy[0]), 64'd0);
    chk("diff_B_busy10", 64'(ifB.rd_busy[1]), 64'd1);
    chk("diff_B_data9", 64'(ifB.rd_data[15:0]), 64'h5A5A);

    // Reset while writes are outstanding: masked during, cleared after
    drv(1'b0, 0, 16'h0000, 1'b0, 0, 7, 10);
    rst = 1'b0;
    #1;
    chkAB("rst_mask", 16'h0000, 1'b0, 16'h0000, 1'b0);
    tick();
    rst = 1'b1;
    drv(1'b0, 0, 16'h0000, 1'b0, 0, 7, 7);
    chkAB("rst_clear", 16'h0000, 1'b0, 16'h0000, 1'b0);

    // Hardwired zero register ignores writes, bypass and issue
    ifC.wr_en = 1'b1; ifC.wr_addr = 4'h0; ifC.wr_data = 32'hFFFF_FFFF;
    ifC.issue_en = 1'b1; ifC.issue_addr = 4'h0; ifC.rd_addr = 12'h000;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("zero_cycle_data%0d", k), 64'(ifC.rd_data[k*32 +: 32]), 64'd0);
      chk($sformatf("zero_cycle_busy%0d", k), 64'(ifC.rd_busy[k]), 64'd0);
    end
    tick();
    ifC.wr_en = 1'b0; ifC.issue_en = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("zero_after_data%0d", k), 64'(ifC.rd_data[k*32 +: 32]), 64'd0);
      chk($sformatf("zero_after_busy%0d", k), 64'(ifC.rd_busy[k]), 64'd0);
    end

    // Randomized regression on the 3-port instance
    for (int i = 0; i < 16; i++) begin
      refRegs[i] = 32'h0;
      refBusy[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 500; cyc++) begin
      rnd_rst = ($urandom_range(0, 39) != 0);
      we = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      ia = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      wd = $urandom();
      for (int k = 0; k < 3; k++) begin
        ra[k] = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      end
      rst = rnd_rst;
      ifC.wr_en = we; ifC.wr_addr = wa; ifC.wr_data = wd;
      ifC.issue_en = ie; ifC.issue_addr = ia;
      ifC.rd_addr = {ra[2], ra[1], ra[0]};
      #1;
      for (int k = 0; k < 3; k++) begin
        if (!rnd_rst || ra[k] == 4'h0) begin
          expD = 32'h0;
          expB = 1'b0;
        end else if (we && wa == ra[k]) begin
          expD = wd;
          expB = 1'b0;
        end else begin
          expD = refRegs[ra[k]];
          expB = refBusy[ra[k]];
        end
        chk($sformatf("rnd%0d_data%0d", cyc, k), 64'(ifC.rd_data[k*32 +: 32]), 64'(expD));
        chk($sformatf("rnd%0d_busy%0d", cyc, k), 64'(ifC.rd_busy[k]), 64'(expB));
      end
      if (!rnd_rst) begin
        for (int i = 0; i < 16; i++) begin
          refRegs[i] = 32'h0;
          refBusy[i] = 1'b0;
        end
      end else begin
        if (we && wa != 4'h0) begin
          refRegs[wa] = wd;
          refBusy[wa] = 1'b0;
        end
        if (ie && ia != 4'h0) begin
          refBusy[ia] = 1'b1;
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-read-port register file. It is the next generation of the fixed 16x16, 2-read/1-write register file.
- Generalised in data width, depth and read-port count.
- Adds a per-register busy scoreboard for pipeline hazard tracking.
- Adds an optional hardwired zero register.
- Sits in the CPU decode stage: feeds operands to execute and receives writeback data.

Parameters:
DATA_W, 16, width of each register in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 0, 1 = register 0 reads as 0, ignores writes and is never busy
BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports and busy is cleared combinationally

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-low
wr_en  in  1  writeback enable
wr_addr  in  ADDR_W  writeback register index
wr_data  in  DATA_W  writeback data
issue_en  in  1  marks issue_addr busy (instruction issued with this destination)
issue_addr  in  ADDR_W  destination register being issued
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  per-port flag: addressed register has a pending write

Behaviour:
- Reset: on a rising clk edge with rst==0, all DEPTH registers are set to 0 and all busy bits to 0.
  - wr_en and issue_en in that cycle are ignored.
  - While rst==0, rd_data = 0 and rd_busy = 0 (combinational masking).
- Storage: reg[wr_addr] <= wr_data at the rising edge when wr_en=1 and rst=1.
- Reads are combinational, with zero latency.
  - BYPASS=1: if wr_en=1 and wr_addr==rd_addr[k], rd_data[k] = wr_data (write-before-read); otherwise rd_data[k] = reg[rd_addr[k]].
  - BYPASS=0: rd_data[k] = reg[rd_addr[k]]; new data is visible from the cycle after the write.
- All read ports are independent. Any number of ports may address the same register, including the write target; each port sees identical data.
- Scoreboard: busy[DEPTH] flops, updated at the rising edge.
  - issue_en=1 sets busy[issue_addr].
  - wr_en=1 clears busy[wr_addr].
  - If issue_en and wr_en target the same address in the same cycle, the set wins: busy stays 1 (new producer issued).
  - Set and clear on different addresses both take effect.
  - rd_busy[k] = busy[rd_addr[k]].
  - BYPASS=1 only: rd_busy[k] is additionally forced to 0 when wr_en=1 and wr_addr==rd_addr[k], because the data is forwarded.
- ZERO_REG=1:
  - Writes to address 0 are discarded, with no bypass.
  - issue_en to address 0 is ignored.
  - Reads of address 0 return 0 with rd_busy=0 regardless of wr_en/wr_data.
- Out-of-range addresses cannot occur, since DEPTH = 2**ADDR_W exactly.
- Reset mid-operation: clears busy bits even while writes are outstanding. The issuing pipeline is also flushed by the same reset.
- No X propagation: reg and busy are fully initialised by reset; reads before the first reset edge are undefined and are not checked.

Test Plan:
1. Reset then read (defaults: DATA_W=16, ADDR_W=4, NUM_RD=2): rst=0 for 2 cycles, then rst=1; read all 16 addresses on both ports -> rd_data=16'h0000, rd_busy=0 everywhere.
2. Write then read, bypass: wr_en=1, wr_addr=5, wr_data=16'hBEEF, rd_addr={5,5} in the same cycle -> both ports show 16'hBEEF in that cycle. Next cycle, wr_en=0 -> still 16'hBEEF.
   - Same stimulus with BYPASS=0 -> 16'h0000 in the write cycle, 16'hBEEF after.
3. Scoreboard: issue_en=1, issue_addr=3 -> next cycle rd_addr port0=3 gives rd_busy[0]=1. Then wr_en=1, wr_addr=3, wr_data=16'h1234:
   - BYPASS=1: rd_busy[0]=0 and rd_data=16'h1234 in that cycle.
   - Following cycle: busy[3]=0.
4. Simultaneous issue and write to the same address: busy[7]=1; wr_en=1, issue_en=1, both addr 7 -> next cycle rd_busy=1 for addr 7 and reg[7]=wr_data.
5. ZERO_REG=1: wr_en=1, wr_addr=0, wr_data=16'hFFFF plus issue_en to addr 0 -> rd_data for addr 0 = 0 in that cycle and after; rd_busy=0.
6. Random regression (NUM_RD=3, DATA_W=32): 500 cycles of random wr_en, wr_addr, wr_data, issue, rd_addr against a reference array model with the same bypass/scoreboard rules. Include rst=0 pulses mid-run -> zero mismatches; all registers are 0 after each reset pulse.
